// File: rtl/spi_alu_pkg.sv
// Shared types and constants for the SPI-driven ALU sequencer.
// The constants cover frame and operand widths, the sequencer state encoding and the default error word.
package spi_alu_pkg;

   localparam int unsigned FRAME_W = 64;
   localparam int unsigned OPND_W  = 32;

   localparam logic [FRAME_W-1:0] ERROR_PATTERN_DEFAULT = 64'hDEAD_DEAD_DEAD_DEAD;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      HOLD,
      COMMIT
   } state_e;

   typedef enum logic {
      DONE_OK,
      DONE_TIMEOUT
   } done_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Reset is asynchronous and active high.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic at_max;
   assign at_max = &count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/spi_alu_sequencer.sv
// Runs one ALU operation per received SPI frame, with a watchdog on the ALU handshake.
// The result is published only while chip select is idle, so a frame never sees a torn result.
module spi_alu_sequencer
   import spi_alu_pkg::*;
#(
   parameter int unsigned        TIMEOUT_CYCLES = 1024,
   parameter logic [FRAME_W-1:0] ERROR_PATTERN  = ERROR_PATTERN_DEFAULT,
   parameter int unsigned        DROP_W         = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_valid,
   input  logic [OPND_W-1:0]  operand1,
   input  logic [OPND_W-1:0]  operand2,
   input  logic               spi_cs_n,
   output logic               alu_start,
   output logic [OPND_W-1:0]  alu_a,
   output logic [OPND_W-1:0]  alu_b,
   input  logic               alu_done,
   input  logic [FRAME_W-1:0] alu_result,
   output logic [FRAME_W-1:0] alu_results,
   output logic               busy,
   output logic               timeout_err,
   output logic [DROP_W-1:0]  drop_count
);

   localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   state_e             state;
   logic [WD_W-1:0]    watchdog;
   logic [FRAME_W-1:0] pending;
   done_e              done_flag;

   assign busy = (state != IDLE);

   sat_counter #(.W(DROP_W)) u_drop_count (
      .clk   (clk),
      .rst   (rst),
      .inc   (frame_valid && busy),
      .count (drop_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         alu_start   <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_results <= '0;
         timeout_err <= 1'b0;
         watchdog    <= '0;
         pending     <= '0;
         done_flag   <= DONE_OK;
      end else begin
         // NOTE: non-blocking assignments, so each branch reads the values held before this edge.
         alu_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (frame_valid) begin
                  alu_a     <= operand1;
                  alu_b     <= operand2;
                  alu_start <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               watchdog <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               // A completion arriving in the expiry cycle still counts as a success.
               if (alu_done) begin
                  pending   <= alu_result;
                  done_flag <= DONE_OK;
                  state     <= HOLD;
               end else if (watchdog == WD_LAST) begin
                  pending   <= ERROR_PATTERN;
                  done_flag <= DONE_TIMEOUT;
                  state     <= HOLD;
               end else begin
                  watchdog <= watchdog + 1'b1;
               end
            end
            HOLD: begin
               if (spi_cs_n) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               alu_results <= pending;
               timeout_err <= (done_flag == DONE_TIMEOUT);
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_alu_sequencer.sv
// Self-checking bench for spi_alu_sequencer: a table of single operations plus hand-written corner sequences.
// The ALU is modelled as a multiplier with a per-test latency; a latency of 0 means the ALU never answers.
module tb_spi_alu_sequencer;

   localparam int unsigned TO = 16;
   localparam int unsigned DW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          frame_valid;
   logic [31:0]   operand1;
   logic [31:0]   operand2;
   logic          spi_cs_n;
   logic          alu_start;
   logic [31:0]   alu_a;
   logic [31:0]   alu_b;
   logic          alu_done;
   logic [63:0]   alu_result;
   logic [63:0]   alu_results;
   logic          busy;
   logic          timeout_err;
   logic [DW-1:0] drop_count;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          model_lat = 0;
   logic        model_force = 1'b0;
   logic [63:0] model_res = '0;
   logic [63:0] prev_res = '0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic [63:0] exp_res;
      logic        exp_terr;
   } vec_t;

   vec_t vecs[8];

   spi_alu_sequencer #(
      .TIMEOUT_CYCLES (TO),
      .ERROR_PATTERN  (64'hDEAD_DEAD_DEAD_DEAD),
      .DROP_W         (DW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_valid (frame_valid),
      .operand1    (operand1),
      .operand2    (operand2),
      .spi_cs_n    (spi_cs_n),
      .alu_start   (alu_start),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_done    (alu_done),
      .alu_result  (alu_result),
      .alu_results (alu_results),
      .busy        (busy),
      .timeout_err (timeout_err),
      .drop_count  (drop_count)
   );

   always #5 clk = ~clk;

   // ALU model: done pulse lands model_lat cycles after the cycle in which alu_start is seen.
   initial begin
      logic [63:0] res;
      alu_done   = 1'b0;
      alu_result = '0;
      forever begin
         @(negedge clk);
         if (alu_start === 1'b1 && model_lat != 0) begin
            res = model_force ? model_res : 64'(alu_a) * 64'(alu_b);
            repeat (model_lat) @(negedge clk);
            alu_done   = 1'b1;
            alu_result = res;
            @(negedge clk);
            alu_done   = 1'b0;
            alu_result = '0;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Call at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic run_op(input vec_t v, input string tag);
      int eff;
      eff = (v.lat == 0 || v.lat > int'(TO)) ? int'(TO) : v.lat;
      model_lat   = v.lat;
      operand1    = v.a;
      operand2    = v.b;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      check({tag, "_start"}, 64'(alu_start), 64'd1);
      check({tag, "_alu_a"}, 64'(alu_a), 64'(v.a));
      check({tag, "_alu_b"}, 64'(alu_b), 64'(v.b));
      check({tag, "_busy"}, 64'(busy), 64'd1);
      @(negedge clk);
      check({tag, "_start_one_cycle"}, 64'(alu_start), 64'd0);
      repeat (eff + 1) @(negedge clk);
      check({tag, "_commit_old"}, alu_results, prev_res);
      check({tag, "_commit_busy"}, 64'(busy), 64'd1);
      @(negedge clk);
      check({tag, "_result"}, alu_results, v.exp_res);
      check({tag, "_terr"}, 64'(timeout_err), 64'(v.exp_terr));
      check({tag, "_idle"}, 64'(busy), 64'd0);
      prev_res = v.exp_res;
      if (v.lat > int'(TO) + 2) begin
         repeat (v.lat - int'(TO) - 2) @(negedge clk);
         check({tag, "_late_done_ignored"}, alu_results, v.exp_res);
         check({tag, "_late_done_idle"}, 64'(busy), 64'd0);
      end
   endtask

   initial begin
      int glitches;

      vecs[0] = '{32'h0000_0003, 32'h0000_0005, 5,  64'h0000_0000_0000_000F, 1'b0};
      vecs[1] = '{32'h0000_0010, 32'h0000_0010, 1,  64'h0000_0000_0000_0100, 1'b0};
      vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3,  64'hFFFF_FFFE_0000_0001, 1'b0};
      vecs[3] = '{32'h0000_0007, 32'h0000_0009, 0,  64'hDEAD_DEAD_DEAD_DEAD, 1'b1};
      vecs[4] = '{32'h1234_5678, 32'h0000_0002, 4,  64'h0000_0000_2468_ACF0, 1'b0};
      vecs[5] = '{32'h0000_0005, 32'h0000_0005, 20, 64'hDEAD_DEAD_DEAD_DEAD, 1'b1};
      vecs[6] = '{32'h0000_0001, 32'h0000_0001, 16, 64'h0000_0000_0000_0001, 1'b0};
      vecs[7] = '{32'h0000_0000, 32'h0000_ABCD, 2,  64'h0000_0000_0000_0000, 1'b0};

      rst         = 1'b1;
      frame_valid = 1'b0;
      operand1    = '0;
      operand2    = '0;
      spi_cs_n    = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_start", 64'(alu_start), 64'd0);
      check("rst_alu_a", 64'(alu_a), 64'd0);
      check("rst_alu_b", 64'(alu_b), 64'd0);
      check("rst_results", alu_results, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_terr", 64'(timeout_err), 64'd0);
      check("rst_drops", 64'(drop_count), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Chip select held low across completion: the result must wait for cs_n to rise.
      model_lat   = 5;
      model_force = 1'b1;
      model_res   = 64'hBEEF_DEAD_DEAD_BEEF;
      operand1    = 32'hBEEF_DEAD;
      operand2    = 32'hDEAD_BEEF;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      spi_cs_n    = 1'b0;
      check("cs_start", 64'(alu_start), 64'd1);
      glitches = 0;
      for (int k = 0; k < 199; k++) begin
         @(negedge clk);
         if (alu_results !== 64'd0 || busy !== 1'b1) glitches++;
      end
      check("cs_hold_glitches", 64'(glitches), 64'd0);
      spi_cs_n = 1'b1;
      @(negedge clk);
      check("cs_commit_old", alu_results, 64'd0);
      @(negedge clk);
      check("cs_result", alu_results, 64'hBEEF_DEAD_DEAD_BEEF);
      check("cs_terr", 64'(timeout_err), 64'd0);
      check("cs_idle", 64'(busy), 64'd0);
      prev_res    = 64'hBEEF_DEAD_DEAD_BEEF;
      model_force = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i], $sformatf("v%0d", i));
      end
      check("no_drops_yet", 64'(drop_count), 64'd0);

      // Four extra frames during one operation: the 2-bit counter saturates at 3.
      model_lat   = 12;
      operand1    = 32'h0000_0011;
      operand2    = 32'h0000_0022;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      check("drop_start", 64'(alu_start), 64'd1);
      for (int k = 0; k < 4; k++) begin
         operand1    = 32'hA000_0000 + 32'(k);
         operand2    = 32'hB000_0000 + 32'(k);
         frame_valid = 1'b1;
         @(negedge clk);
         frame_valid = 1'b0;
         @(negedge clk);
      end
      check("drop_count_sat", 64'(drop_count), 64'd3);
      check("drop_alu_a", 64'(alu_a), 64'h11);
      check("drop_alu_b", 64'(alu_b), 64'h22);
      check("drop_busy", 64'(busy), 64'd1);
      repeat (6) @(negedge clk);
      check("drop_commit_old", alu_results, prev_res);
      @(negedge clk);
      check("drop_result", alu_results, 64'h242);
      check("drop_idle", 64'(busy), 64'd0);
      prev_res = 64'h242;

      // Asynchronous reset between clock edges while the ALU is still working.
      model_lat   = 10;
      operand1    = 32'h0000_0021;
      operand2    = 32'h0000_0003;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_start", 64'(alu_start), 64'd0);
      check("arst_alu_a", 64'(alu_a), 64'd0);
      check("arst_alu_b", 64'(alu_b), 64'd0);
      check("arst_results", alu_results, 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_terr", 64'(timeout_err), 64'd0);
      check("arst_drops", 64'(drop_count), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("arst_late_done_idle", 64'(busy), 64'd0);
      check("arst_late_done_results", alu_results, 64'd0);
      prev_res = 64'd0;
      run_op('{32'h0000_0021, 32'h0000_0003, 6, 64'h0000_0000_0000_0063, 1'b0}, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
